// File: rtl/fifo_pkg.sv
// fifo_pkg: shared status struct and depth helper for the FIFO pointer controller
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: push/pop requests, storage addressing and status of the FIFO controller
interface fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    import fifo_pkg::*;

    logic                  wr;
    logic                  rd;
    logic                  err_clr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, rd, err_clr,
        input  wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  wr, rd, err_clr,
        output wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping W-bit pointer that advances on each accepted request
module fifo_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);
    logic [W-1:0] ptr_q, ptr_d;

    // next pointer: binary rollover gives the modulo-depth wrap for free
    always_comb ptr_d = inc_i ? ptr_q + 1'b1 : ptr_q;

    // pointer register, cleared by reset
    always_ff @(posedge clk) ptr_q <= reset ? '0 : ptr_d;

    assign ptr_o = ptr_q;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FWFT FIFO pointer/status controller; sticky overflow/underflow flags built only with FIFO_CTRL_ERR_EN
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH-2,
    parameter int AE_LEVEL   = 2
) (
    input  logic      clk,
    input  logic      reset,
    fifo_ctrl_if.slave bus
);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int LW    = ADDR_WIDTH + 1;

    logic [LW-1:0] level_q, level_d;
    logic          push, pop, ovf, udf;
    fifo_status_t  st;

    // a push is still taken when full if a pop frees the head slot in the same cycle
    assign push = bus.wr & (~st.full | bus.rd);
    assign pop  = bus.rd & ~st.empty;

    // occupancy moves only when exactly one side is accepted
    always_comb level_d = (push & ~pop) ? level_q + 1'b1 : (pop & ~push) ? level_q - 1'b1 : level_q;

    // occupancy register
    always_ff @(posedge clk) level_q <= reset ? '0 : level_d;

    fifo_ptr #(.W(ADDR_WIDTH)) u_wptr (.clk(clk), .reset(reset), .inc_i(push), .ptr_o(bus.w_addr));
    fifo_ptr #(.W(ADDR_WIDTH)) u_rptr (.clk(clk), .reset(reset), .inc_i(pop),  .ptr_o(bus.r_addr));

`ifdef FIFO_CTRL_ERR_EN
    logic ovf_q, udf_q;

    // sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= (bus.wr & ~push) | (ovf_q & ~bus.err_clr);
            udf_q <= (bus.rd & ~pop)  | (udf_q & ~bus.err_clr);
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

    // status decoded from registered state only, so wr/rd never reach it combinationally
    always_comb begin
        st.full         = level_q == LW'(DEPTH);
        st.empty        = level_q == '0;
        st.almost_full  = level_q >= LW'(AF_LEVEL);
        st.almost_empty = level_q <= LW'(AE_LEVEL);
        st.overflow     = ovf;
        st.underflow    = udf;
    end

    assign bus.wr_en        = push;
    assign bus.level        = level_q;
    assign bus.full         = st.full;
    assign bus.empty        = st.empty;
    assign bus.almost_full  = st.almost_full;
    assign bus.almost_empty = st.almost_empty;
    assign bus.overflow     = st.overflow;
    assign bus.underflow    = st.underflow;
endmodule
